mem_sequencer: RTL and testbench
================================

Name: mem_sequencer

Overview:
- Multi-cycle sequencer that lets the single-cycle RISC-V core (fetch via `instr`, data via `readdata`/`aluresult`/`writedata`/`memwrite`) share one unified memory port.
- Fetches each instruction, then performs at most one load/store for it, then pulses a core step-enable (`core_en`) so the core's PC and register file advance exactly once per instruction.
- Sits between the core top level and a single-ported, variable-latency memory.

Parameters:
- XLEN, 32, data and address width.
- TIMEOUT, 16, maximum wait cycles per memory request before the error state (at least 2).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- core_pc  input  XLEN  PC from the core.
- core_aluresult  input  XLEN  data address from the core.
- core_writedata  input  XLEN  store data from the core.
- core_memwrite  input  1  store indication from the core.
- core_instr  output  XLEN  latched instruction to the core.
- core_readdata  output  XLEN  latched load data to the core.
- core_en  output  1  one-cycle step enable for the core's PC and register-file write.
- mem_req  output  1  memory request.
- mem_we  output  1  write strobe, valid while mem_req=1.
- mem_addr  output  XLEN  memory address.
- mem_wdata  output  XLEN  write data.
- mem_rdata  input  XLEN  read data, valid when mem_ack=1.
- mem_ack  input  1  memory completion.
- err  output  1  sticky timeout flag.
- retire_cnt  output  CNT_W  count of retired instructions.

Behaviour:
- **Reset values** (asynchronous, active-high, applied while rst=1):
  - state=IDLE, core_instr=32'h00000013 (NOP), core_readdata=0.
  - core_en=0, mem_req=0, mem_we=0, err=0, retire_cnt=0, wait counter=0.
- **States:** IDLE, FETCH, EXEC, DATA, COMMIT, ERROR.
- **Output decode:** mem_req, mem_we, mem_addr, mem_wdata and core_en decode combinationally from state and registered data only. Internal registers update on the clk rising edge.
- **IDLE:** go to FETCH on the next cycle.
- **FETCH:**
  - mem_req=1, mem_we=0, mem_addr=core_pc.
  - On mem_ack=1: latch core_instr<=mem_rdata and go to EXEC.
- **EXEC:** one settle cycle so the core's combinational decode and ALU see the new core_instr.
  - Classify using opcode core_instr[6:0]: 7'b0000011 is a load, 7'b0100011 is a store.
  - Load or store: go to DATA, registering addr<=core_aluresult, wdata<=core_writedata, we<=core_memwrite.
  - Otherwise: go to COMMIT.
- **DATA:**
  - mem_req=1; mem_addr, mem_wdata and mem_we come from the EXEC-registered values.
  - On mem_ack=1: a load latches core_readdata<=mem_rdata; go to COMMIT.
- **COMMIT:**
  - core_en=1 for exactly this cycle; retire_cnt increments and wraps modulo 2^CNT_W.
  - Next state is FETCH.
  - core_readdata holds its value through COMMIT, so the load write-back sees stable data.
- **Handshake rules:**
  - While mem_req=1, mem_addr, mem_we and mem_wdata are stable until mem_ack is sampled high.
  - Zero-wait ack (ack in the first request cycle) is legal.
  - mem_ack is ignored while mem_req=0.
  - mem_req drops in the cycle after the ack.
- **Latency:** non-memory instruction is 3 cycles minimum (FETCH, EXEC, COMMIT); load/store is 4 cycles minimum. Each memory wait cycle adds one.
- **Timeout:**
  - The wait counter clears on entry to FETCH or DATA and increments each cycle without ack.
  - If it reaches TIMEOUT-1 with no ack, go to ERROR.
  - ERROR: err=1 (sticky), mem_req=0, core_en=0, held until reset.
- **Reset mid-operation:** returns to IDLE immediately with mem_req=0. Any in-flight transaction is abandoned; memory must tolerate a dropped request.
- **Store completion:** memory ack ends the access; no read data is latched.
- **Loop guard:** core_en never asserts outside COMMIT, and memory is never requested in EXEC or COMMIT, so the core's combinational PC-to-address path cannot loop.

Test Plan:
- **Reset:**
  - Stimulus: hold rst=1 for 3 cycles.
  - Required: core_instr=32'h00000013, core_en=0, mem_req=0, retire_cnt=0, err=0; mem_req rises 2 cycles after rst falls.
- **ADDI, zero-wait memory:**
  - Stimulus: memory returns 32'h00500093 for addr 0.
  - Required: FETCH, EXEC, COMMIT; core_en high exactly 1 cycle; retire_cnt=1; no DATA request.
- **Load with 3 wait cycles:**
  - Stimulus: instr 32'h0000A103, core_aluresult=32'h100, mem_rdata=32'hDEADBEEF.
  - Required: DATA request with mem_we=0 and addr 32'h100 held stable 4 cycles; core_readdata=32'hDEADBEEF during COMMIT.
- **Store:**
  - Stimulus: instr 32'h0020A223, core_writedata=32'h12345678.
  - Required: mem_we=1 and mem_wdata=32'h12345678 throughout DATA; one core_en; core_readdata unchanged.
- **Timeout:**
  - Stimulus: mem_ack never asserted, TIMEOUT=16.
  - Required: after 16 FETCH cycles, err=1, mem_req=0, core_en=0 forever; rst clears err.
- **Reset during a DATA wait:**
  - Stimulus: assert rst mid-DATA, then run 5 back-to-back ADDIs.
  - Required: mem_req drops asynchronously; retire_cnt=5 after 15 cycles with zero-wait memory.

Source files
------------

// File: rtl/mem_sequencer_if.sv
// Unified memory port shared by instruction fetch and data access.
// The sequencer is the master; a single-ported, variable-latency memory is the slave.
interface mem_sequencer_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;
  logic            ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_sequencer.sv
// Multi-cycle sequencer: fetch, optional load/store, then a one-cycle core step
// enable, so a single-cycle core can run on one shared variable-latency memory.
module mem_sequencer #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  core_pc,
  input  logic [XLEN-1:0]  core_aluresult,
  input  logic [XLEN-1:0]  core_writedata,
  input  logic             core_memwrite,
  output logic [XLEN-1:0]  core_instr,
  output logic [XLEN-1:0]  core_readdata,
  output logic             core_en,
  mem_sequencer_if.master  mem,
  output logic             err,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int              WAIT_W    = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [6:0]      OP_LOAD   = 7'b0000011;
  localparam logic [6:0]      OP_STORE  = 7'b0100011;
  localparam logic [XLEN-1:0] NOP       = XLEN'(32'h00000013);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, DATA, COMMIT, ERROR} state_t;

  state_t            state_reg, state_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic [XLEN-1:0]   instr_reg, rdata_reg, addr_reg, wdata_reg;
  logic              we_reg, err_reg;
  logic [CNT_W-1:0]  retire_reg;
  logic              is_load, is_store;

  assign is_load       = (instr_reg[6:0] == OP_LOAD);
  assign is_store      = (instr_reg[6:0] == OP_STORE);
  assign core_instr    = instr_reg;
  assign core_readdata = rdata_reg;
  assign err           = err_reg;
  assign retire_cnt    = retire_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      wait_reg   <= '0;
      instr_reg  <= NOP;
      rdata_reg  <= '0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      we_reg     <= 1'b0;
      err_reg    <= 1'b0;
      retire_reg <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      if (state_reg == FETCH && mem.ack)
        instr_reg <= mem.rdata;
      // Data-phase address/data are frozen here so the bus stays stable while waiting.
      if (state_reg == EXEC && (is_load || is_store)) begin
        addr_reg  <= core_aluresult;
        wdata_reg <= core_writedata;
        we_reg    <= core_memwrite;
      end
      if (state_reg == DATA && mem.ack && is_load)
        rdata_reg <= mem.rdata;
      if (state_reg == COMMIT)
        retire_reg <= retire_reg + CNT_W'(1);
      if (state_next == ERROR)
        err_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    mem.req    = 1'b0;
    mem.we     = 1'b0;
    mem.addr   = addr_reg;
    mem.wdata  = wdata_reg;
    core_en    = 1'b0;
    case (state_reg)
      IDLE: begin
        state_next = FETCH;
        wait_next  = '0;
      end
      FETCH: begin
        mem.req  = 1'b1;
        mem.addr = core_pc;
        if (mem.ack) begin
          state_next = EXEC;
        end else if (wait_reg == WAIT_LAST) begin
          state_next = ERROR;
        end else begin
          wait_next = wait_reg + WAIT_W'(1);
        end
      end
      EXEC: begin
        // Settle cycle: the core decodes the freshly latched instruction.
        if (is_load || is_store) begin
          state_next = DATA;
          wait_next  = '0;
        end else begin
          state_next = COMMIT;
        end
      end
      DATA: begin
        mem.req = 1'b1;
        mem.we  = we_reg;
        if (mem.ack) begin
          state_next = COMMIT;
        end else if (wait_reg == WAIT_LAST) begin
          state_next = ERROR;
        end else begin
          wait_next = wait_reg + WAIT_W'(1);
        end
      end
      COMMIT: begin
        core_en    = 1'b1;
        state_next = FETCH;
        wait_next  = '0;
      end
      ERROR: begin
        state_next = ERROR;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_sequencer.sv
// Self-checking bench for mem_sequencer: a randomised memory responder plus a
// per-instruction latency/traffic model derived from the sequencing rules.
module tb_mem_sequencer;
  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst;
  logic [XLEN-1:0]  core_pc, core_aluresult, core_writedata;
  logic             core_memwrite;
  logic [XLEN-1:0]  core_instr, core_readdata;
  logic             core_en, err;
  logic [CNT_W-1:0] retire_cnt;

  mem_sequencer_if #(.XLEN(XLEN)) mem_bus ();

  mem_sequencer #(.XLEN(XLEN), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .core_pc(core_pc), .core_aluresult(core_aluresult),
    .core_writedata(core_writedata), .core_memwrite(core_memwrite),
    .core_instr(core_instr), .core_readdata(core_readdata), .core_en(core_en),
    .mem(mem_bus), .err(err), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory contents and per-request latencies are owned by the stimulus side.
  logic [31:0] mem_arr [logic [31:0]];
  int          lat_tab [$];

  // Responder-owned state.
  int          req_no, wcnt, cur_lat;
  bit          busy;
  logic [31:0] st_addr, st_data;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return a ^ 32'h5A5A0000;
  endfunction

  // Responds at the falling edge so the DUT samples ack/rdata at the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      mem_bus.ack   = 1'b0;
      mem_bus.rdata = '0;
      busy = 1'b0; wcnt = 0; req_no = 0; cur_lat = 0;
    end else if (mem_bus.req) begin
      if (!busy) begin
        busy = 1'b1; wcnt = 0;
        cur_lat = (req_no < lat_tab.size()) ? lat_tab[req_no] : 0;
        req_no++;
      end
      if (wcnt == cur_lat) begin
        mem_bus.ack = 1'b1;
        busy = 1'b0;
        if (mem_bus.we) begin
          st_addr = mem_bus.addr; st_data = mem_bus.wdata;
          mem_bus.rdata = $urandom();
        end else begin
          mem_bus.rdata = rd_word(mem_bus.addr);
        end
      end else begin
        mem_bus.ack   = 1'b0;
        mem_bus.rdata = $urandom();
        wcnt++;
      end
    end else begin
      // Spurious acks while idle must be ignored by the sequencer.
      busy = 1'b0;
      mem_bus.ack   = 1'($urandom_range(0, 1));
      mem_bus.rdata = $urandom();
    end
  end

  // Observations of one instruction, captured by run_one.
  int          o_cycles, o_runs, o_flen, o_dlen;
  bit          o_en, o_fstable, o_dstable;
  logic [31:0] o_faddr, o_daddr, o_dwdata, o_rd, o_instr;
  logic        o_fwe, o_dwe;
  logic [CNT_W-1:0] o_retire;

  logic [CNT_W-1:0] exp_retire;
  logic [31:0]      exp_rd;

  function automatic bit is_memop(input logic [31:0] ins);
    return (ins[6:0] == 7'b0000011) || (ins[6:0] == 7'b0100011);
  endfunction

  // Starts at a falling edge just before a FETCH cycle; ends at the falling edge of COMMIT.
  task automatic run_one(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] wd, input int lf, input int ld);
    logic prev;
    mem_arr[pc]    = instr;
    core_pc        = pc;
    core_aluresult = alu;
    core_writedata = wd;
    core_memwrite  = (instr[6:0] == 7'b0100011);
    lat_tab.push_back(lf);
    if (is_memop(instr)) lat_tab.push_back(ld);
    o_cycles = 0; o_runs = 0; o_flen = 0; o_dlen = 0; o_en = 1'b0;
    o_fstable = 1'b1; o_dstable = 1'b1; prev = 1'b0;
    o_faddr = 'x; o_daddr = 'x; o_dwdata = 'x; o_fwe = 1'bx; o_dwe = 1'bx;
    while (!o_en && o_cycles < 64) begin
      @(negedge clk);
      o_cycles++;
      if (mem_bus.req && !prev) begin
        o_runs++;
        if (o_runs == 1) begin
          o_faddr = mem_bus.addr; o_fwe = mem_bus.we;
        end else if (o_runs == 2) begin
          o_daddr = mem_bus.addr; o_dwe = mem_bus.we; o_dwdata = mem_bus.wdata;
        end
      end
      if (mem_bus.req) begin
        if (o_runs == 1) begin
          o_flen++;
          if (mem_bus.addr !== o_faddr || mem_bus.we !== o_fwe) o_fstable = 1'b0;
        end else begin
          o_dlen++;
          if (mem_bus.addr !== o_daddr || mem_bus.we !== o_dwe || mem_bus.wdata !== o_dwdata)
            o_dstable = 1'b0;
        end
      end
      if (core_en) begin
        o_en = 1'b1; o_rd = core_readdata; o_instr = core_instr; o_retire = retire_cnt;
      end
      prev = mem_bus.req;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    lat_tab.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    exp_retire = '0;
    exp_rd     = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    lat_tab.delete();
    core_pc = 32'h0; core_aluresult = '0; core_writedata = '0; core_memwrite = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (core_instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h expected %h", core_instr, NOP); end
    checks++; if (core_en !== 1'b0 || mem_bus.req !== 1'b0 || mem_bus.we !== 1'b0) begin errors++; $display("FAIL reset_ctrl: got en=%b req=%b we=%b expected 0 0 0", core_en, mem_bus.req, mem_bus.we); end
    checks++; if (retire_cnt !== '0 || err !== 1'b0 || core_readdata !== '0) begin errors++; $display("FAIL reset_regs: got retire=%0d err=%b rd=%h expected 0 0 0", retire_cnt, err, core_readdata); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (mem_bus.req !== 1'b0) begin errors++; $display("FAIL reset_idle_req: got %b expected 0", mem_bus.req); end
    @(negedge clk);
    checks++; if (mem_bus.req !== 1'b1 || mem_bus.addr !== core_pc) begin errors++; $display("FAIL reset_first_fetch: got req=%b addr=%h expected 1 %h", mem_bus.req, mem_bus.addr, core_pc); end
  endtask

  task automatic test_addi();
    do_reset();
    run_one(32'h00500093, 32'h0, $urandom(), $urandom(), 0, 0);
    checks++; if (o_cycles !== 3) begin errors++; $display("FAIL addi_cycles: got %0d expected 3", o_cycles); end
    checks++; if (o_runs !== 1 || o_faddr !== 32'h0 || o_fwe !== 1'b0) begin errors++; $display("FAIL addi_traffic: got runs=%0d addr=%h we=%b expected 1 0 0", o_runs, o_faddr, o_fwe); end
    checks++; if (o_instr !== 32'h00500093) begin errors++; $display("FAIL addi_instr: got %h expected 00500093", o_instr); end
    @(negedge clk);
    checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL addi_en_width: got %b expected 0", core_en); end
    checks++; if (retire_cnt !== CNT_W'(1)) begin errors++; $display("FAIL addi_retire: got %0d expected 1", retire_cnt); end
  endtask

  task automatic test_load_store();
    do_reset();
    mem_arr[32'h100] = 32'hDEADBEEF;
    run_one(32'h0000A103, 32'h0, 32'h100, $urandom(), 0, 3);
    checks++; if (o_cycles !== 7) begin errors++; $display("FAIL load_cycles: got %0d expected 7", o_cycles); end
    checks++; if (o_dlen !== 4 || !o_dstable) begin errors++; $display("FAIL load_hold: got len=%0d stable=%b expected 4 1", o_dlen, o_dstable); end
    checks++; if (o_daddr !== 32'h100 || o_dwe !== 1'b0) begin errors++; $display("FAIL load_req: got addr=%h we=%b expected 00000100 0", o_daddr, o_dwe); end
    checks++; if (o_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data: got %h expected deadbeef", o_rd); end
    run_one(32'h0020A223, 32'h4, 32'h104, 32'h12345678, 1, 2);
    checks++; if (o_cycles !== 7) begin errors++; $display("FAIL store_cycles: got %0d expected 7", o_cycles); end
    checks++; if (o_dwe !== 1'b1 || o_dwdata !== 32'h12345678 || !o_dstable || o_dlen !== 3) begin errors++; $display("FAIL store_req: got we=%b wdata=%h stable=%b len=%0d expected 1 12345678 1 3", o_dwe, o_dwdata, o_dstable, o_dlen); end
    checks++; if (o_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL store_rd_kept: got %h expected deadbeef", o_rd); end
    checks++; if (st_addr !== 32'h104 || st_data !== 32'h12345678) begin errors++; $display("FAIL store_mem: got %h@%h expected 12345678@00000104", st_data, st_addr); end
    checks++; if (o_retire !== CNT_W'(1)) begin errors++; $display("FAIL store_retire: got %0d expected 1", o_retire); end
  endtask

  task automatic test_random();
    logic [31:0] r, ins, pc, alu, wd;
    logic [6:0]  opc;
    int lf, ld, exp_cyc;
    bit m;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       opc = 7'b0000011;
        1:       opc = 7'b0100011;
        2:       opc = 7'b0010011;
        default: opc = 7'b0110011;
      endcase
      r   = $urandom();
      ins = {r[31:7], opc};
      pc  = 32'($urandom_range(0, 1023)) * 4;
      alu = 32'h1000 + 32'($urandom_range(0, 1023)) * 4;
      wd  = $urandom();
      lf  = $urandom_range(0, 3);
      ld  = $urandom_range(0, 3);
      m   = is_memop(ins);
      if (opc == 7'b0000011) begin
        exp_rd = $urandom();
        mem_arr[alu] = exp_rd;
      end
      exp_cyc = (lf + 1) + 1 + (m ? ld + 1 : 0) + 1;
      run_one(ins, pc, alu, wd, lf, ld);
      checks++; if (o_cycles !== exp_cyc) begin errors++; $display("FAIL rand_cycles[%0d]: got %0d expected %0d", i, o_cycles, exp_cyc); end
      checks++; if (o_flen !== lf + 1 || o_faddr !== pc || o_fwe !== 1'b0 || !o_fstable) begin errors++; $display("FAIL rand_fetch[%0d]: got len=%0d addr=%h we=%b stable=%b expected %0d %h 0 1", i, o_flen, o_faddr, o_fwe, o_fstable, lf + 1, pc); end
      checks++; if (o_runs !== (m ? 2 : 1)) begin errors++; $display("FAIL rand_runs[%0d]: got %0d expected %0d", i, o_runs, m ? 2 : 1); end
      if (m) begin
        checks++; if (o_dlen !== ld + 1 || o_daddr !== alu || o_dwe !== (opc == 7'b0100011) || o_dwdata !== wd || !o_dstable) begin errors++; $display("FAIL rand_data[%0d]: got len=%0d addr=%h we=%b wdata=%h stable=%b expected %0d %h %b %h 1", i, o_dlen, o_daddr, o_dwe, o_dwdata, o_dstable, ld + 1, alu, opc == 7'b0100011, wd); end
      end
      checks++; if (o_rd !== exp_rd) begin errors++; $display("FAIL rand_readdata[%0d]: got %h expected %h", i, o_rd, exp_rd); end
      checks++; if (o_instr !== ins) begin errors++; $display("FAIL rand_instr[%0d]: got %h expected %h", i, o_instr, ins); end
      checks++; if (o_retire !== exp_retire) begin errors++; $display("FAIL rand_retire[%0d]: got %0d expected %0d", i, o_retire, exp_retire); end
      exp_retire = exp_retire + CNT_W'(1);
    end
    @(negedge clk);
    checks++; if (retire_cnt !== exp_retire) begin errors++; $display("FAIL rand_retire_final: got %0d expected %0d", retire_cnt, exp_retire); end
  endtask

  task automatic test_timeout();
    int n, early, bad;
    do_reset();
    core_pc = 32'h40;
    lat_tab.push_back(1000);
    n = 0; early = 0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!mem_bus.req) break;
      n++;
      if (err) early++;
    end
    checks++; if (n !== TIMEOUT) begin errors++; $display("FAIL timeout_fetch_cycles: got %0d expected %0d", n, TIMEOUT); end
    checks++; if (err !== 1'b1 || early !== 0) begin errors++; $display("FAIL timeout_err: got err=%b early=%0d expected 1 0", err, early); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_bus.req || core_en || !err) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL timeout_hold: got %0d bad cycles expected 0", bad); end
    rst = 1'b1;
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL timeout_rst_clear: got %b expected 0", err); end
  endtask

  task automatic test_back_to_back();
    int total;
    do_reset();
    core_pc = 32'h0; core_aluresult = 32'h1100; core_memwrite = 1'b0;
    mem_arr[32'h0] = 32'h0000A103;
    lat_tab.push_back(0);
    lat_tab.push_back(50);
    repeat (4) @(negedge clk);
    checks++; if (mem_bus.req !== 1'b1 || mem_bus.addr !== 32'h1100) begin errors++; $display("FAIL mid_data_req: got req=%b addr=%h expected 1 00001100", mem_bus.req, mem_bus.addr); end
    #2 rst = 1'b1;
    #1;
    checks++; if (mem_bus.req !== 1'b0 || core_en !== 1'b0) begin errors++; $display("FAIL async_drop: got req=%b en=%b expected 0 0", mem_bus.req, core_en); end
    lat_tab.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    exp_retire = '0;
    total = 0;
    for (int i = 0; i < 5; i++) begin
      run_one(32'h00500093, 32'(i * 4), $urandom(), $urandom(), 0, 0);
      total += o_cycles;
    end
    checks++; if (total !== 15) begin errors++; $display("FAIL b2b_cycles: got %0d expected 15", total); end
    @(negedge clk);
    checks++; if (retire_cnt !== CNT_W'(5)) begin errors++; $display("FAIL b2b_retire: got %0d expected 5", retire_cnt); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_addi();
    test_load_store();
    test_random();
    test_timeout();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
